seq_det_110101: RTL and testbench
=================================

Name: seq_det_110101

Overview:
- Serial bit-stream pattern detector for the 6-bit sequence 1-1-0-1-0-1 (first-received bit leftmost).
- Samples one input bit per rising clock edge.
- Asserts a one-cycle Moore-style pulse when the most recent six sampled bits equal 110101.
- Detection is overlapping. Sits on a serial data path as a framing/marker detector and optionally counts matches.

Parameters:
- CNT_W, 8: width of the match counter output match_cnt (legal range 1..32).

Ports:
- clk  input  1  clock; all sampling on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in  input  1  serial data bit, sampled every rising clk edge while rstn=1.
- out  output  1  detect pulse; high for exactly one cycle per match.
- match_cnt  output  CNT_W  saturating count of matches since reset (see Optional Feature).

Behaviour:
- Reset: rstn=0 asynchronously forces state=IDLE, out=0, match_cnt=0. Held while rstn=0; in is ignored.
- Reset release: the first rising edge with rstn=1 samples in normally.
- Reset asserted mid-sequence: partial progress is discarded; the detector restarts from IDLE.
- States (longest matched prefix): IDLE, S1 ("1"), S11, S110, S1101, S11010, DET ("110101"). Use a 3-bit encoding; encoding value 7 is unused.
- Transitions on each rising edge (in=0 / in=1):
  - IDLE: IDLE / S1
  - S1: IDLE / S11
  - S11: S110 / S11
  - S110: IDLE / S1101
  - S1101: S11010 / S11
  - S11010: IDLE / DET
  - DET: IDLE / S11
  - Unused encoding: IDLE / IDLE (recovery)
- Output: out = 1 iff state==DET (registered state, Moore). out rises in the cycle after the edge that samples the final '1' and stays high for exactly one clock.
- Latency: 1 clock from the sampling edge of the last pattern bit to out high.
- Overlap: the trailing "1" of a match is reused, so 11010110101 produces two pulses. Back-to-back matches are at least 5 bits apart; out is never high on consecutive cycles.
- match_cnt: increments by 1 on every edge that enters DET. Saturates at 2^CNT_W-1 with no wrap.
- No X-propagation: out and match_cnt are always driven.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined: match_cnt is a CNT_W-bit register behaving as above (async reset to 0, increments on entry to DET, saturates).
- Not defined: no counter flops are instantiated, match_cnt is tied to all zeros, and out behaviour is identical.

Test Plan:
- Reset hold: rstn=0 for 5 clocks with in toggling -> out=0 and match_cnt=0 throughout. State is IDLE after release.
- Single match: after reset, drive 1,1,0,1,0,1 on successive edges -> out=1 exactly in the cycle after the 6th sample, then 0. match_cnt=1 (with SEQ_DET_CNT_EN).
- Overlap stream: drive 1,1,0,1,0,1,1,1,0,1,0,1 -> two one-cycle pulses, after the 6th and 12th samples. match_cnt=2.
- Near misses: drive 1,1,0,1,1,0,1,0,1 -> the 1101 prefix resets into S11; exactly one pulse, after the 9th sample.
- Mid-sequence reset: drive 1,1,0,1,0, pulse rstn low asynchronously between edges, then drive 1 -> no pulse. The following 1,1,0,1,0,1 gives one pulse.
- Saturation (CNT_W=2, macro defined): 5 matches in sequence -> match_cnt reads 1,2,3,3,3. out pulses 5 times.

Source files
------------

// File: rtl/seq_det_110101_if.sv
// rtl/seq_det_110101_if.sv - serial bit in, detect pulse and match count out
interface seq_det_110101_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in,
    input  out,
    input  match_cnt
  );

  modport slave (
    input  in,
    output out,
    output match_cnt
  );
endinterface

// File: rtl/seq_det_110101.sv
// rtl/seq_det_110101.sv - overlapping 110101 serial pattern detector, Moore pulse
// Match counter built only when SEQ_DET_CNT_EN is defined; otherwise match_cnt is zero.
module seq_det_110101 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  seq_det_110101_if.slave    bus
);

  // State value = length of the longest matched prefix; 7 is unused.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] S1     = 3'd1;
  localparam logic [2:0] S11    = 3'd2;
  localparam logic [2:0] S110   = 3'd3;
  localparam logic [2:0] S1101  = 3'd4;
  localparam logic [2:0] S11010 = 3'd5;
  localparam logic [2:0] DET    = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.in ? S1    : IDLE;
      S1:      state_nxt = bus.in ? S11   : IDLE;
      S11:     state_nxt = bus.in ? S11   : S110;
      S110:    state_nxt = bus.in ? S1101 : IDLE;
      S1101:   state_nxt = bus.in ? S11   : S11010;
      S11010:  state_nxt = bus.in ? DET   : IDLE;
      // Trailing '1' of a match is kept so overlapping matches are found.
      DET:     state_nxt = bus.in ? S11   : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign bus.out = (state == DET);

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // DET is never re-entered from itself, so entry equals state_nxt == DET.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if ((state_nxt == DET) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_110101.sv
// tb/tb_seq_det_110101.sv - self-checking bench for seq_det_110101 (CNT_W=2)
module tb_seq_det_110101;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rstn;

  seq_det_110101_if #(.CNT_W(CNT_W)) bus ();

  seq_det_110101 #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the detector fires when the last six samples since reset read 110101.
  bit [5:0] hist   = '0;
  int       nseen  = 0;
  bit       m_out  = 1'b0;
  int       m_cnt  = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist  = '0;
      nseen = 0;
      m_out = 1'b0;
      m_cnt = 0;
    end else begin
      hist = {hist[4:0], bus.in};
      if (nseen < 6) nseen++;
      m_out = (nseen == 6) && (hist == 6'b110101);
      if (m_out && CNT_ON && (m_cnt < MAXC)) m_cnt++;
    end
  end

  always @(negedge clk) begin
    check("out_vs_model", {31'd0, bus.out}, {31'd0, m_out});
    check("cnt_vs_model", {30'd0, bus.match_cnt}, m_cnt);
  end

  int         npulse;
  int         first_idx;
  int         last_idx;
  logic [1:0] cnt_seen [8];

  function automatic logic [31:0] exp_cnt(input int k);
    return CNT_ON ? k : 0;
  endfunction

  task automatic run_bits(input logic [31:0] pat, input int len);
    npulse    = 0;
    first_idx = 0;
    last_idx  = 0;
    for (int i = 0; i < len; i++) begin
      bus.in = pat[len-1-i];
      @(posedge clk);
      #2;
      if (bus.out === 1'b1) begin
        npulse++;
        if (first_idx == 0) first_idx = i + 1;
        last_idx = i + 1;
        if (npulse <= 8) cnt_seen[npulse-1] = bus.match_cnt;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn   = 1'b0;
    bus.in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn   = 1'b0;
    bus.in = 1'b0;

    // Reset hold with input toggling
    for (int i = 0; i < 5; i++) begin
      bus.in = ~bus.in;
      @(posedge clk);
      #2;
      check("rst_hold_out", {31'd0, bus.out}, 0);
      check("rst_hold_cnt", {30'd0, bus.match_cnt}, 0);
    end
    rstn = 1'b1;

    // Single match straight out of reset
    run_bits(32'b110101, 6);
    check("single_npulse", npulse, 1);
    check("single_idx", first_idx, 6);
    check("single_cnt", {30'd0, cnt_seen[0]}, exp_cnt(1));
    run_bits(32'b0, 1);
    check("single_drop", {31'd0, bus.out}, 0);

    // Overlap stream of two full patterns
    do_reset();
    run_bits(32'b110101110101, 12);
    check("ovl_npulse", npulse, 2);
    check("ovl_first", first_idx, 6);
    check("ovl_last", last_idx, 12);
    check("ovl_cnt", {30'd0, bus.match_cnt}, exp_cnt(2));

    // Shared trailing '1'
    do_reset();
    run_bits(32'b11010110101, 11);
    check("share_npulse", npulse, 2);
    check("share_last", last_idx, 11);

    // Near miss: 1101 then 1 falls back into S11
    do_reset();
    run_bits(32'b110110101, 9);
    check("near_npulse", npulse, 1);
    check("near_idx", first_idx, 9);

    // Mid-sequence asynchronous reset between edges
    do_reset();
    run_bits(32'b11010, 5);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_out", {31'd0, bus.out}, 0);
    check("midrst_cnt", {30'd0, bus.match_cnt}, 0);
    #1;
    rstn = 1'b1;
    run_bits(32'b1, 1);
    check("midrst_nopulse", npulse, 0);
    run_bits(32'b110101, 6);
    check("midrst_after", npulse, 1);

    // Saturation: five matches chained through the shared '1'
    do_reset();
    run_bits(32'b11010110101101011010110101, 26);
    check("sat_npulse", npulse, 5);
    check("sat_cnt0", {30'd0, cnt_seen[0]}, exp_cnt(1));
    check("sat_cnt1", {30'd0, cnt_seen[1]}, exp_cnt(2));
    check("sat_cnt2", {30'd0, cnt_seen[2]}, exp_cnt(3));
    check("sat_cnt3", {30'd0, cnt_seen[3]}, exp_cnt(3));
    check("sat_cnt4", {30'd0, cnt_seen[4]}, exp_cnt(3));

    // Pseudo-random tail, checked cycle by cycle against the model
    for (int i = 0; i < 300; i++) begin
      bus.in = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
